pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 RST  input  1  synchronous reset, active-high.
REQ-003 ID_RA0, ID_RA1  input  5 each  source register addresses of instruction in ID.
REQ-004 ID_USE0, ID_USE1  input  1 each  instruction in ID actually reads RA0 / RA1.
REQ-005 EX_WA, MEM_WA  input  5 each  destination of instruction in EX / MEM.
REQ-006 EX_WEN, MEM_WEN  input  1 each  instruction in EX / MEM writes the register file.
REQ-007 EX_LOAD  input  1  instruction in EX is LD/LDR.
REQ-008 EX_BR_TAKEN  input  1  branch/jump resolved taken in EX this cycle.
REQ-009 MEM_WAIT  input  1  data access not complete; MEM stage cannot retire.
REQ-010 PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL  output  1 each  hold the named register.
REQ-011 IFID_FLUSH, IDEX_FLUSH  output  1 each  load bubble into the named register.
REQ-012 FWD_A, FWD_B  output  2 each  EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result.
REQ-013 STALL_CNT, FLUSH_CNT  output  16 each  performance counters.
REQ-014 WAIT_ERR  output  1  sticky memory-wait timeout flag.

Function
REQ-015 FSM states: RUN, MWAIT; RUN->MWAIT when MEM_WAIT=1; MWAIT->RUN when MEM_WAIT=0.
REQ-016 While MEM_WAIT=1, regardless of state: PC_STALL, IFID_STALL, IDEX_STALL, EXMEM_STALL =1; both flushes =0; FWD_A/FWD_B held.
REQ-017 While MEM_WAIT=1, EX_BR_TAKEN is ignored; it takes effect on the first cycle with MEM_WAIT=0.
REQ-018 Load-use (MEM_WAIT=0, EX_BR_TAKEN=0, EX_LOAD=1, EX_WEN=1, EX_WA matches a used ID source): PC_STALL=1, IFID_STALL=1, IDEX_FLUSH=1, for exactly one cycle per load.
REQ-019 Taken branch (MEM_WAIT=0, EX_BR_TAKEN=1): IFID_FLUSH=1, IDEX_FLUSH=1, no stalls; overrides a coincident load-use stall.
REQ-020 Stall/flush outputs are combinational from current inputs and state; no added latency.
REQ-021 FWD_A/FWD_B are registered: computed from ID comparisons, presented the cycle the instruction is in EX.
REQ-022 Forward priority: EX_WEN match -> 01, else MEM_WEN match -> 10, else 00; USE bit 0 forces 00.
REQ-023 On a cycle with IDEX_FLUSH=1, FWD_A/FWD_B load 00.
REQ-024 Register 0 is an ordinary register; matches on address 0 are hazards.
REQ-025 Register file writes before reads within a cycle; WB-stage matches need no action.
REQ-026 STALL_CNT increments on every cycle with PC_STALL=1; FLUSH_CNT on every cycle with IFID_FLUSH=1; both saturate at 16'hFFFF.
REQ-027 8-bit wait counter increments each cycle in MWAIT with MEM_WAIT=1, clears on return to RUN; WAIT_ERR sets when it reaches 255 and stays set until reset.

Reset
REQ-028 RST=1: state RUN; FWD_A, FWD_B = 00; STALL_CNT, FLUSH_CNT, wait counter = 0; WAIT_ERR = 0.
REQ-029 Combinational stall/flush outputs are forced 0 while RST=1.
REQ-030 RST asserted mid-MWAIT or mid-stall aborts it; first cycle after reset evaluates inputs from RUN.

Configuration
REQ-031 Macro PIPE_FORWARD_EN defined: forwarding per REQ-021..023, stalls only per REQ-018.
REQ-032 PIPE_FORWARD_EN undefined: FWD_A/FWD_B tied 00; any used ID source matching a writing EX or MEM destination raises PC_STALL, IFID_STALL, IDEX_FLUSH until cleared; REQ-016/019 priority unchanged.

Structure
REQ-033 Shared package risc_toy_pkg holds FWD encodings, FSM state encodings, register-address width (5), counter width (16), wait limit (255).
REQ-034 One sub-module hazard_cmp: compares one source address/use bit against EX and MEM destinations, returns match flags; instantiated twice.

Verification
REQ-035 Reset, then idle inputs -> all stall/flush 0, FWD 00, counters 0.
REQ-036 EX: LOAD, WA=5, WEN=1; ID: RA0=5, USE0=1 -> one cycle PC_STALL=IFID_STALL=IDEX_FLUSH=1; next EX cycle FWD_A=10; STALL_CNT=1.
REQ-037 EX ADD WA=3; ID RA1=3, USE1=1; MEM WA=3 also writing -> FWD_B=01 (EX wins).
REQ-038 EX_BR_TAKEN=1 same cycle as load-use -> IFID_FLUSH=IDEX_FLUSH=1, PC_STALL=0; FLUSH_CNT=1.
REQ-039 MEM_WAIT=1 for 256 cycles with EX_BR_TAKEN=1 -> all four stalls 1, no flush, WAIT_ERR=1 after cycle 255; drop MEM_WAIT -> flushes fire one cycle.
REQ-040 PIPE_FORWARD_EN undefined, EX ADD WA=7, ID RA0=7 -> stall two cycles (EX then MEM), FWD_A stays 00.

Source files
------------

// File: rtl/risc_toy_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc_toy_pkg
//  Description : Shared constants for the pipeline hazard controller:
//                forwarding-select encodings, FSM state encodings,
//                register-address / counter widths and memory-wait limit.
//  Revision    : 1.0  initial release
// ============================================================================
package risc_toy_pkg;

    localparam int c_REG_AW = 5;
    localparam int c_CNT_W  = 16;
    localparam int c_WAIT_W = 8;

    localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT = 8'd255;

    // EX operand select codes
    localparam logic [1:0] c_FWD_REGFILE = 2'b00;
    localparam logic [1:0] c_FWD_EXMEM   = 2'b01;
    localparam logic [1:0] c_FWD_MEMWB   = 2'b10;

    // Memory-wait FSM states
    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_MWAIT = 1'b1;

    // The youngest producer (currently in EX) wins over the older one in MEM.
    function automatic logic [1:0] fwd_select(input logic ex_match, input logic mem_match);
        if (ex_match) begin
            return c_FWD_EXMEM;
        end else if (mem_match) begin
            return c_FWD_MEMWB;
        end
        return c_FWD_REGFILE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_cmp
//  Description : Compares one ID source operand against the EX and MEM
//                destinations. A match needs the source to be read and the
//                producer to write; register 0 is treated like any other.
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_cmp
    import risc_toy_pkg::*;
(
    input  logic [c_REG_AW-1:0] ra,
    input  logic                use_src,
    input  logic [c_REG_AW-1:0] ex_wa,
    input  logic                ex_wen,
    input  logic [c_REG_AW-1:0] mem_wa,
    input  logic                mem_wen,
    output logic                ex_match,
    output logic                mem_match
);

    // Match flags gated by the use bit and the producer write enables
    always_comb begin
        ex_match  = use_src && ex_wen  && (ra == ex_wa);
        mem_match = use_src && mem_wen && (ra == mem_wa);
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall / flush / forwarding control for a 5-stage pipeline,
//                with performance counters and a memory-wait watchdog.
//                Build option: define PIPE_FORWARD_EN to enable operand
//                forwarding (only load-use then stalls); otherwise any RAW
//                dependency on EX or MEM stalls and forwarding is tied off.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import risc_toy_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [c_REG_AW-1:0] id_ra0,
    input  logic [c_REG_AW-1:0] id_ra1,
    input  logic                id_use0,
    input  logic                id_use1,
    input  logic [c_REG_AW-1:0] ex_wa,
    input  logic [c_REG_AW-1:0] mem_wa,
    input  logic                ex_wen,
    input  logic                mem_wen,
    input  logic                ex_load,
    input  logic                ex_br_taken,
    input  logic                mem_wait,
    output logic                pc_stall,
    output logic                ifid_stall,
    output logic                idex_stall,
    output logic                exmem_stall,
    output logic                ifid_flush,
    output logic                idex_flush,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [c_CNT_W-1:0]  stall_cnt,
    output logic [c_CNT_W-1:0]  flush_cnt,
    output logic                wait_err
);

    logic w_ex_match0, w_mem_match0;
    logic w_ex_match1, w_mem_match1;
    logic w_hazard;

    logic [0:0]          r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_wait_err;
    logic [c_CNT_W-1:0]  r_stall_cnt;
    logic [c_CNT_W-1:0]  r_flush_cnt;

    hazard_cmp u_cmp0 (
        .ra        (id_ra0),
        .use_src   (id_use0),
        .ex_wa     (ex_wa),
        .ex_wen    (ex_wen),
        .mem_wa    (mem_wa),
        .mem_wen   (mem_wen),
        .ex_match  (w_ex_match0),
        .mem_match (w_mem_match0)
    );

    hazard_cmp u_cmp1 (
        .ra        (id_ra1),
        .use_src   (id_use1),
        .ex_wa     (ex_wa),
        .ex_wen    (ex_wen),
        .mem_wa    (mem_wa),
        .mem_wen   (mem_wen),
        .ex_match  (w_ex_match1),
        .mem_match (w_mem_match1)
    );

`ifdef PIPE_FORWARD_EN
    logic [1:0] r_fwd_a;
    logic [1:0] r_fwd_b;

    // Only a load in EX cannot be forwarded in time
    assign w_hazard = ex_load && (w_ex_match0 || w_ex_match1);

    // Forward selects move into EX with the instruction; held while IDEX holds
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fwd_a <= c_FWD_REGFILE;
            r_fwd_b <= c_FWD_REGFILE;
        end else if (idex_stall) begin
            r_fwd_a <= r_fwd_a;
            r_fwd_b <= r_fwd_b;
        end else if (idex_flush) begin
            r_fwd_a <= c_FWD_REGFILE;
            r_fwd_b <= c_FWD_REGFILE;
        end else begin
            r_fwd_a <= fwd_select(w_ex_match0, w_mem_match0);
            r_fwd_b <= fwd_select(w_ex_match1, w_mem_match1);
        end
    end

    assign fwd_a = r_fwd_a;
    assign fwd_b = r_fwd_b;
`else
    logic w_unused_load;

    // Without forwarding every pending write in EX or MEM must drain first
    assign w_hazard = w_ex_match0 || w_ex_match1 || w_mem_match0 || w_mem_match1;
    assign w_unused_load = ex_load;
    assign fwd_a = c_FWD_REGFILE;
    assign fwd_b = c_FWD_REGFILE;
`endif

    // Priority: memory wait freezes everything, then taken branch, then RAW stall
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
            end else if (ex_br_taken) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
            end else if (w_hazard) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_flush  = 1'b1;
            end
        end
    end

    // Memory-wait FSM with saturating wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_RUN;
            r_wait_cnt <= '0;
            r_wait_err <= 1'b0;
        end else begin
            r_state <= mem_wait ? c_ST_MWAIT : c_ST_RUN;
            if ((r_state == c_ST_MWAIT) && mem_wait) begin
                if (r_wait_cnt != c_WAIT_LIMIT) begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
                if (r_wait_cnt >= (c_WAIT_LIMIT - 8'd1)) begin
                    r_wait_err <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign wait_err  = r_wait_err;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Self-checking bench for pipe_hazard_ctrl: directed pipeline
//                scenarios followed by randomized inputs, all compared
//                against a rule-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [4:0]  id_ra0, id_ra1, ex_wa, mem_wa;
    logic        id_use0, id_use1, ex_wen, mem_wen, ex_load, ex_br_taken, mem_wait;
    logic        pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;
    logic        wait_err;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int       m_stall, m_flush, m_run;
    bit       m_err;
    bit [1:0] m_fwd_a, m_fwd_b;
    bit       e_pc, e_ifid_st, e_idex_st, e_exmem_st, e_ifid_fl, e_idex_fl;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_ra0(id_ra0), .id_ra1(id_ra1), .id_use0(id_use0), .id_use1(id_use1),
        .ex_wa(ex_wa), .mem_wa(mem_wa), .ex_wen(ex_wen), .mem_wen(mem_wen),
        .ex_load(ex_load), .ex_br_taken(ex_br_taken), .mem_wait(mem_wait),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall),
        .exmem_stall(exmem_stall), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .wait_err(wait_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic bit hit(input logic [4:0] ra, input logic u,
                               input logic [4:0] wa, input logic wen);
        return u && wen && (ra == wa);
    endfunction

    // code the instruction in ID should see once it reaches EX
    function automatic bit [1:0] src_code(input logic [4:0] ra, input logic u);
        if (hit(ra, u, ex_wa, ex_wen))   return 2'd1;
        if (hit(ra, u, mem_wa, mem_wen)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compute_exp();
        bit ex_dep, mem_dep, hazard;
        ex_dep  = hit(id_ra0, id_use0, ex_wa, ex_wen) || hit(id_ra1, id_use1, ex_wa, ex_wen);
        mem_dep = hit(id_ra0, id_use0, mem_wa, mem_wen) || hit(id_ra1, id_use1, mem_wa, mem_wen);
        hazard  = FWD_EN ? (ex_load && ex_dep) : (ex_dep || mem_dep);
        {e_pc, e_ifid_st, e_idex_st, e_exmem_st, e_ifid_fl, e_idex_fl} = '0;
        if (rst) begin
        end else if (mem_wait) begin
            {e_pc, e_ifid_st, e_idex_st, e_exmem_st} = 4'hF;
        end else if (ex_br_taken) begin
            {e_ifid_fl, e_idex_fl} = 2'b11;
        end else if (hazard) begin
            {e_pc, e_ifid_st, e_idex_fl} = 3'b111;
        end
    endtask

    // compare every output against the model, away from the active edge
    task automatic sample();
        @(negedge clk);
        compute_exp();
        chk("pc_stall",    pc_stall,    e_pc);
        chk("ifid_stall",  ifid_stall,  e_ifid_st);
        chk("idex_stall",  idex_stall,  e_idex_st);
        chk("exmem_stall", exmem_stall, e_exmem_st);
        chk("ifid_flush",  ifid_flush,  e_ifid_fl);
        chk("idex_flush",  idex_flush,  e_idex_fl);
        chk("fwd_a",       fwd_a,       m_fwd_a);
        chk("fwd_b",       fwd_b,       m_fwd_b);
        chk("stall_cnt",   stall_cnt,   m_stall);
        chk("flush_cnt",   flush_cnt,   m_flush);
        chk("wait_err",    wait_err,    m_err);
    endtask

    // advance one clock and apply the rules to the model
    task automatic clock();
        @(posedge clk);
        compute_exp();
        if (rst) begin
            m_stall = 0; m_flush = 0; m_run = 0; m_err = 0;
            m_fwd_a = 0; m_fwd_b = 0;
        end else begin
            if (e_pc && m_stall < 65535) m_stall++;
            if (e_ifid_fl && m_flush < 65535) m_flush++;
            m_run = mem_wait ? m_run + 1 : 0;
            if (m_run >= 256) m_err = 1;
            if (FWD_EN && !mem_wait) begin
                if (e_idex_fl) begin
                    m_fwd_a = 0; m_fwd_b = 0;
                end else begin
                    m_fwd_a = src_code(id_ra0, id_use0);
                    m_fwd_b = src_code(id_ra1, id_use1);
                end
            end
        end
        #1;
    endtask

    task automatic idle();
        {id_ra0, id_ra1, ex_wa, mem_wa} = '0;
        {id_use0, id_use1, ex_wen, mem_wen, ex_load, ex_br_taken, mem_wait} = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        clock();
        sample();
        clock();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        m_stall = 0; m_flush = 0; m_run = 0; m_err = 0; m_fwd_a = 0; m_fwd_b = 0;

        // reset then idle
        do_reset();
        sample();
        chk("idle_stall_cnt", stall_cnt, 0);
        chk("idle_fwd_a", fwd_a, 0);
        clock();

`ifdef PIPE_FORWARD_EN
        // load-use: one stall cycle, then forwarding from MEM/WB
        do_reset();
        ex_load = 1; ex_wen = 1; ex_wa = 5; id_ra0 = 5; id_use0 = 1;
        sample();
        chk("lu_pc_stall", pc_stall, 1);
        chk("lu_idex_flush", idex_flush, 1);
        clock();
        ex_load = 0; ex_wen = 0; mem_wa = 5; mem_wen = 1;
        sample();
        chk("lu_second_cycle", pc_stall, 0);
        clock();
        idle();
        sample();
        chk("lu_fwd_a", fwd_a, 2'b10);
        chk("lu_stall_cnt", stall_cnt, 1);
        clock();

        // EX producer wins over MEM producer
        do_reset();
        ex_wa = 3; ex_wen = 1; mem_wa = 3; mem_wen = 1; id_ra1 = 3; id_use1 = 1;
        sample();
        chk("alu_no_stall", pc_stall, 0);
        clock();
        idle();
        sample();
        chk("ex_wins_fwd_b", fwd_b, 2'b01);
        clock();
`else
        // no forwarding: dependency stalls while producer is in EX then MEM
        do_reset();
        ex_wa = 7; ex_wen = 1; id_ra0 = 7; id_use0 = 1;
        sample();
        chk("nf_stall_ex", pc_stall, 1);
        clock();
        ex_wen = 0; mem_wa = 7; mem_wen = 1;
        sample();
        chk("nf_stall_mem", pc_stall, 1);
        clock();
        idle();
        sample();
        chk("nf_released", pc_stall, 0);
        chk("nf_fwd_a", fwd_a, 0);
        chk("nf_stall_cnt", stall_cnt, 2);
        clock();
`endif

        // taken branch overrides coincident load-use
        do_reset();
        ex_load = 1; ex_wen = 1; ex_wa = 0; id_ra0 = 0; id_use0 = 1; ex_br_taken = 1;
        sample();
        chk("br_ifid_flush", ifid_flush, 1);
        chk("br_pc_stall", pc_stall, 0);
        clock();
        idle();
        sample();
        chk("br_flush_cnt", flush_cnt, 1);
        clock();

        // long memory wait with pending branch, then release
        do_reset();
        mem_wait = 1; ex_br_taken = 1;
        for (int i = 0; i < 256; i++) begin
            sample();
            if (i == 255) chk("wait_err_not_yet", wait_err, 0);
            clock();
        end
        sample();
        chk("wait_err_set", wait_err, 1);
        chk("wait_exmem_stall", exmem_stall, 1);
        clock();
        mem_wait = 0;
        sample();
        chk("release_flush", idex_flush, 1);
        clock();
        ex_br_taken = 0;
        sample();
        chk("release_flush_cnt", flush_cnt, 1);
        chk("wait_err_sticky", wait_err, 1);
        clock();

        // randomized traffic, including resets mid-wait or mid-stall
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 39) == 0);
            id_ra0      = 5'($urandom_range(0, 3));
            id_ra1      = 5'($urandom_range(0, 3));
            ex_wa       = 5'($urandom_range(0, 3));
            mem_wa      = 5'($urandom_range(0, 3));
            id_use0     = 1'($urandom);
            id_use1     = 1'($urandom);
            ex_wen      = 1'($urandom);
            mem_wen     = 1'($urandom);
            ex_load     = 1'($urandom);
            ex_br_taken = ($urandom_range(0, 5) == 0);
            mem_wait    = ($urandom_range(0, 7) == 0);
            sample();
            clock();
        end
        rst = 1'b0;
        idle();
        sample();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
